// File: rtl/gate_controller.sv
// ----------------------------------------------------------------------------
// gate_controller
//
// Gate/door controller FSM driving a reversible motor, two status LEDs and an
// active-low 7-segment digit. It sits between debounced board switches and the
// motor driver/display.
//
// Parameters:
//   TRAVEL_MAX  max cycles allowed in ABRINDO/FECHANDO before a fault (>= 2)
//   AUTO_CLOSE  cycles in ABERTO before closing by itself (>= 1); only used
//               when GATE_AUTOCLOSE_EN is defined
//
// Optional feature macro:
//   GATE_AUTOCLOSE_EN  builds the auto-close counter. When it is undefined,
//                      ABERTO leaves only on a button press or a fault.
//
// Ports:
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   botao         in   command button (level, asynchronous)
//   fim_aberto    in   open limit switch, 1 = fully open
//   fim_fechado   in   closed limit switch, 1 = fully closed
//   obstaculo     in   obstacle sensor, 1 = blocked
//   motor_on      out  motor enable
//   motor_dir     out  0 = opening, 1 = closing (valid while motor_on = 1)
//   led_verde     out  lit while ABRINDO
//   led_vermelho  out  lit while FECHANDO or FALHA
//   falha         out  fault latched
//   display       out  active-low segments {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module gate_controller #(
    parameter int unsigned TRAVEL_MAX = 1000,
    parameter int unsigned AUTO_CLOSE = 5000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       botao,
    input  logic       fim_aberto,
    input  logic       fim_fechado,
    input  logic       obstaculo,
    output logic       motor_on,
    output logic       motor_dir,
    output logic       led_verde,
    output logic       led_vermelho,
    output logic       falha,
    output logic [6:0] display
);

    typedef enum logic [2:0] {
        FECHADO  = 3'd0,
        ABRINDO  = 3'd1,
        ABERTO   = 3'd2,
        FECHANDO = 3'd3,
        PARADO   = 3'd4,
        FALHA    = 3'd5
    } state_t;

    localparam int unsigned TW = $clog2(TRAVEL_MAX + 1);

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_F    = 7'b0001110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_P    = 7'b0001100;
    localparam logic [6:0] SEG_E    = 7'b0000110;

    // Elaboration-time parameter sanity checks
    if (TRAVEL_MAX < 2) begin : g_bad_travel_max
        $error("gate_controller: TRAVEL_MAX must be at least 2");
    end
    if (AUTO_CLOSE < 1) begin : g_bad_auto_close
        $error("gate_controller: AUTO_CLOSE must be at least 1");
    end

    // ------------------------------------------------------------------
    // Input synchronisers and button edge detector
    // ------------------------------------------------------------------
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       botao_prev;
    logic       botao_s;
    logic       aberto_s;
    logic       fechado_s;
    logic       obst_s;
    logic       press;

    assign {botao_s, aberto_s, fechado_s, obst_s} = sync2;
    // One pulse per press: synced button low on the previous cycle, high now
    assign press = botao_s & ~botao_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            botao_prev <= 1'b0;
        end else begin
            sync1      <= {botao, fim_aberto, fim_fechado, obstaculo};
            sync2      <= sync1;
            botao_prev <= botao_s;
        end
    end

    // ------------------------------------------------------------------
    // State, travel timer and direction memory
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          timer_full;
    logic          last_close;
    logic          ac_expired;
    logic          travel_now;
    logic          travel_entry;

    assign timer_full   = (timer == TW'(TRAVEL_MAX));
    assign travel_now   = (state == ABRINDO) || (state == FECHANDO);
    assign travel_entry = ((state_next == ABRINDO) || (state_next == FECHANDO))
                          && (state_next != state);

`ifdef GATE_AUTOCLOSE_EN
    localparam int unsigned AW = $clog2(AUTO_CLOSE + 1);

    logic [AW-1:0] ac_count;

    assign ac_expired = (ac_count == AW'(AUTO_CLOSE)) && !obst_s;

    // Restarts on entry to ABERTO and on every blocked cycle, so the gate
    // closes only after AUTO_CLOSE consecutive obstacle-free cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ac_count <= '0;
        end else if ((state_next == ABERTO) && (state != ABERTO)) begin
            ac_count <= '0;
        end else if (obst_s) begin
            ac_count <= '0;
        end else if ((state == ABERTO) && (ac_count != AW'(AUTO_CLOSE))) begin
            ac_count <= ac_count + AW'(1);
        end
    end
`else
    assign ac_expired = 1'b0;
`endif

    // Next-state logic; priority is top-down inside each state
    always_comb begin
        state_next = state;
        if (aberto_s && fechado_s) begin
            // Both limits active at once can only be a sensor fault
            state_next = FALHA;
        end else begin
            case (state)
                FECHADO: begin
                    if (press) state_next = ABRINDO;
                end
                ABRINDO: begin
                    if (aberto_s)        state_next = ABERTO;
                    else if (timer_full) state_next = FALHA;
                    else if (press)      state_next = PARADO;
                end
                ABERTO: begin
                    if (press || ac_expired) state_next = FECHANDO;
                end
                FECHANDO: begin
                    if (obst_s)          state_next = ABRINDO;
                    else if (fechado_s)  state_next = FECHADO;
                    else if (timer_full) state_next = FALHA;
                    else if (press)      state_next = PARADO;
                end
                PARADO: begin
                    if (press) state_next = last_close ? ABRINDO : FECHANDO;
                end
                FALHA: begin
                    state_next = FALHA;
                end
                default: begin
                    state_next = FECHADO;
                end
            endcase
        end
    end

    // Registered Moore outputs are decoded from state_next so that they
    // change on the same edge as the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FECHADO;
            timer        <= '0;
            last_close   <= 1'b0;
            motor_on     <= 1'b0;
            motor_dir    <= 1'b0;
            led_verde    <= 1'b0;
            led_vermelho <= 1'b0;
            falha        <= 1'b0;
            display      <= SEG_F;
        end else begin
            state <= state_next;

            // Remember the direction of travel for resuming from PARADO
            if (state == ABRINDO) begin
                last_close <= 1'b0;
            end else if (state == FECHANDO) begin
                last_close <= 1'b1;
            end

            if (travel_entry) begin
                timer <= '0;
            end else if (travel_now && !timer_full) begin
                timer <= timer + TW'(1);
            end

            motor_on     <= 1'b0;
            motor_dir    <= 1'b0;
            led_verde    <= 1'b0;
            led_vermelho <= 1'b0;
            falha        <= 1'b0;
            display      <= SEG_F;
            case (state_next)
                FECHADO: begin
                    display <= SEG_F;
                end
                ABRINDO: begin
                    motor_on  <= 1'b1;
                    led_verde <= 1'b1;
                    display   <= SEG_DASH;
                end
                ABERTO: begin
                    display <= SEG_A;
                end
                FECHANDO: begin
                    motor_on     <= 1'b1;
                    motor_dir    <= 1'b1;
                    led_vermelho <= 1'b1;
                    display      <= SEG_DASH;
                end
                PARADO: begin
                    display <= SEG_P;
                end
                FALHA: begin
                    led_vermelho <= 1'b1;
                    falha        <= 1'b1;
                    display      <= SEG_E;
                end
                default: begin
                    display <= SEG_F;
                end
            endcase
        end
    end

endmodule
